cp0_regfile: RTL and testbench
==============================

Name: cp0_regfile

Overview:
- Coprocessor-0 register file that sits directly downstream of the exception unit.
- Commits the exception unit's cp0_exp_* / cp0_exl_clean requests into the architectural CP0 state.
- Serves MFC0/MTC0 from the pipeline.
- Feeds the status back upstream: epc_address, allow_interrupt, interrupt_flag, cp0_ebase, the vector-select bits, exl_set, asid.
- Implements the Count/Compare timer and samples external interrupts.

Parameters:
PRID, 32'h0000_4220, read-only PRId (reg 15 sel 0) value
CONFIG0, 32'h8000_0000, read-only Config (reg 16 sel 0) value

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-low (asserted when 0)
raddr  in  5  MFC0 register number
rsel  in  3  MFC0 select
rdata  out  32  MFC0 read data, combinational
wen  in  1  MTC0 write enable
waddr  in  5  MTC0 register number
wsel  in  3  MTC0 select
wdata  in  32  MTC0 data
hw_int  in  6  external interrupt lines, level, asynchronous to pipeline
cp0_exp_en  in  1  commit exception
cp0_exl_clean  in  1  ERET commit
cp0_exp_epc  in  32  EPC candidate
cp0_exp_code  in  5  ExcCode
cp0_exp_bd  in  1  branch-delay flag
cp0_exp_bad_vaddr  in  32  BadVAddr candidate
cp0_exp_bad_vaddr_wen  in  1  BadVAddr update enable
cp0_exp_asid  in  8  ASID for EntryHi
cp0_exp_asid_en  in  1  EntryHi update enable
epc_address  out  32  EPC register
allow_interrupt  out  1  Status.IE & ~Status.EXL
interrupt_flag  out  8  Cause.IP[7:0] & Status.IM[7:0]
cp0_ebase  out  32  EBase register
cp0_use_special_iv  out  1  Cause.IV
cp0_use_bootstrap_iv  out  1  Status.BEV
exl_set  out  1  Status.EXL
asid  out  8  EntryHi.ASID

Behaviour:
- Reset (rst=0, async): BadVAddr=0, Count=0, Compare=0, EntryHi=0, Status=32'h0040_0000 (BEV=1), Cause=0, EPC=0, EBase=32'h8000_0000, count_toggle=0, hw_int sample regs=0. All outputs follow these values.
- Implemented registers (num/sel): BadVAddr 8/0, Count 9/0, EntryHi 10/0, Compare 11/0, Status 12/0, Cause 13/0, EPC 14/0, PRId 15/0, EBase 15/1, Config 16/0.
- Unimplemented num/sel reads return 0; writes to them are ignored.
- Read: combinational from current register state. A write in the same cycle is not visible until the next cycle; forwarding is the pipeline's job.
- Write masks: only these bits take wdata; all other bits are unchanged.
  - Status: [22] BEV, [15:8] IM, [1] EXL, [0] IE.
  - Cause: [23] IV, [9:8] IP[1:0].
  - EntryHi: [31:13], [7:0].
  - EBase: [29:12]; [31:30] stay 2'b10.
  - Count, Compare, EPC: full 32 bits.
  - BadVAddr, PRId, Config: read-only.
- Count:
  - count_toggle flips every cycle; Count increments (mod 2^32) on cycles where count_toggle=1, i.e. at half clock rate.
  - MTC0 Count loads wdata and clears count_toggle; this takes precedence over the increment.
- Timer:
  - Cause.TI (bit 30) is set on the cycle Count==Compare, evaluated on registered values.
  - MTC0 Compare clears TI in that same cycle; the clear wins over a same-cycle set.
- Interrupt pending:
  - hw_int passes through a 2-flop synchronizer. Cause.IP[7:2] is written each cycle: IP[6:2]=sync[4:0], IP[7]=sync[5]|TI.
  - IP[1:0] are software-written only.
- Exception commit (cp0_exp_en=1):
  - If Status.EXL=0: EPC<=cp0_exp_epc and Cause.BD<=cp0_exp_bd.
  - If Status.EXL=1: EPC and BD are held.
  - Always: Status.EXL<=1 and Cause.ExcCode[6:2]<=cp0_exp_code.
  - cp0_exp_bad_vaddr_wen: BadVAddr<=cp0_exp_bad_vaddr.
  - cp0_exp_asid_en: EntryHi[31:13]<=cp0_exp_bad_vaddr[31:13] and EntryHi[7:0]<=cp0_exp_asid.
- ERET (cp0_exl_clean=1): Status.EXL<=0. cp0_exp_en and cp0_exl_clean are mutually exclusive by construction.
- Priority: an exception/ERET update beats an MTC0 to the same field in the same cycle. The MTC0 still updates the fields the exception does not touch.
- Latency: all updates become visible on the outputs one cycle after the request (registered). The Count==Compare match reaches interrupt_flag[7] two cycles after the match condition.

Test Plan:
- Release reset -> rdata for 12/0 is 32'h0040_0000 and for 15/1 is 32'h8000_0000; cp0_use_bootstrap_iv=1; allow_interrupt=0.
- MTC0 12/0 with 32'hFFFF_FFFF -> Status reads 32'h0040_FF03; MTC0 15/1 with 32'h0000_0000 -> EBase reads 32'h8000_0000.
- cp0_exp_en with epc=32'h8000_1004, bd=1, code=5'h0c -> EPC=32'h8000_1004, Cause[31]=1, Cause[6:2]=5'h0c, exl_set=1. A second exception with epc=32'h8000_2000 -> EPC unchanged, ExcCode updated. cp0_exl_clean -> exl_set=0.
- Write Compare=5, Count=0, Status IM7=1, IE=1 -> TI sets once Count==5 (after about 10 cycles); interrupt_flag=8'h80. MTC0 Compare -> TI and interrupt_flag[7] clear.
- hw_int=6'b000001 with IM2=1 -> interrupt_flag=8'h04 three cycles later; deassert -> it clears with the same latency.
- Same cycle: cp0_exp_en plus MTC0 12/0 with EXL=0, IE=1 -> EXL=1 (exception wins), IE=1 (MTC0 applied).

Source files
------------

// File: rtl/cp0_regfile_if.sv
// Pipeline / exception-unit side of the CP0 register file: MFC0/MTC0 access,
// exception commit requests and the status fed back upstream.
interface cp0_regfile_if;
    logic [4:0]  raddr;
    logic [2:0]  rsel;
    logic [31:0] rdata;
    logic        wen;
    logic [4:0]  waddr;
    logic [2:0]  wsel;
    logic [31:0] wdata;
    logic [5:0]  hw_int;
    logic        cp0_exp_en;
    logic        cp0_exl_clean;
    logic [31:0] cp0_exp_epc;
    logic [4:0]  cp0_exp_code;
    logic        cp0_exp_bd;
    logic [31:0] cp0_exp_bad_vaddr;
    logic        cp0_exp_bad_vaddr_wen;
    logic [7:0]  cp0_exp_asid;
    logic        cp0_exp_asid_en;
    logic [31:0] epc_address;
    logic        allow_interrupt;
    logic [7:0]  interrupt_flag;
    logic [31:0] cp0_ebase;
    logic        cp0_use_special_iv;
    logic        cp0_use_bootstrap_iv;
    logic        exl_set;
    logic [7:0]  asid;

    modport master (
        output raddr, rsel, wen, waddr, wsel, wdata, hw_int,
               cp0_exp_en, cp0_exl_clean, cp0_exp_epc, cp0_exp_code, cp0_exp_bd,
               cp0_exp_bad_vaddr, cp0_exp_bad_vaddr_wen, cp0_exp_asid, cp0_exp_asid_en,
        input  rdata, epc_address, allow_interrupt, interrupt_flag, cp0_ebase,
               cp0_use_special_iv, cp0_use_bootstrap_iv, exl_set, asid
    );

    modport slave (
        input  raddr, rsel, wen, waddr, wsel, wdata, hw_int,
               cp0_exp_en, cp0_exl_clean, cp0_exp_epc, cp0_exp_code, cp0_exp_bd,
               cp0_exp_bad_vaddr, cp0_exp_bad_vaddr_wen, cp0_exp_asid, cp0_exp_asid_en,
        output rdata, epc_address, allow_interrupt, interrupt_flag, cp0_ebase,
               cp0_use_special_iv, cp0_use_bootstrap_iv, exl_set, asid
    );
endinterface

// File: rtl/cp0_regfile.sv
// CP0 register file: architectural state, Count/Compare timer, interrupt sampling.
// Reads are combinational; every update lands one cycle after the request. No backpressure.
module cp0_regfile #(
    parameter logic [31:0] PRID    = 32'h0000_4220,
    parameter logic [31:0] CONFIG0 = 32'h8000_0000
) (
    input  logic          clk,
    input  logic          rst,
    cp0_regfile_if.slave  bus
);
    localparam logic [7:0] A_BADV   = {5'd8,  3'd0};
    localparam logic [7:0] A_COUNT  = {5'd9,  3'd0};
    localparam logic [7:0] A_ENTHI  = {5'd10, 3'd0};
    localparam logic [7:0] A_CMP    = {5'd11, 3'd0};
    localparam logic [7:0] A_STATUS = {5'd12, 3'd0};
    localparam logic [7:0] A_CAUSE  = {5'd13, 3'd0};
    localparam logic [7:0] A_EPC    = {5'd14, 3'd0};
    localparam logic [7:0] A_PRID   = {5'd15, 3'd0};
    localparam logic [7:0] A_EBASE  = {5'd15, 3'd1};
    localparam logic [7:0] A_CONFIG = {5'd16, 3'd0};

    localparam logic [31:0] STATUS_WMASK = 32'h0040_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0080_0300;
    localparam logic [31:0] ENTHI_WMASK  = 32'hFFFF_E0FF;
    localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
    localparam logic [31:0] EBASE_RST    = 32'h8000_0000;

    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q,    count_d;
    logic [31:0] compare_q,  compare_d;
    logic [31:0] entryhi_q,  entryhi_d;
    logic [31:0] status_q,   status_d;
    logic [31:0] cause_q,    cause_d;
    logic [31:0] epc_q,      epc_d;
    logic [31:0] ebase_q,    ebase_d;
    logic        count_toggle_q, count_toggle_d;
    logic [5:0]  hw_sync1_q, hw_sync1_d;
    logic [5:0]  hw_sync2_q, hw_sync2_d;

    logic [7:0]  waddr_sel;
    logic        wr_count, wr_cmp, wr_status, wr_cause, wr_enthi, wr_epc, wr_ebase;

    always_comb begin
        waddr_sel = {bus.waddr, bus.wsel};
        wr_count  = bus.wen && (waddr_sel == A_COUNT);
        wr_cmp    = bus.wen && (waddr_sel == A_CMP);
        wr_status = bus.wen && (waddr_sel == A_STATUS);
        wr_cause  = bus.wen && (waddr_sel == A_CAUSE);
        wr_enthi  = bus.wen && (waddr_sel == A_ENTHI);
        wr_epc    = bus.wen && (waddr_sel == A_EPC);
        wr_ebase  = bus.wen && (waddr_sel == A_EBASE);
    end

    always_comb begin
        badvaddr_d     = badvaddr_q;
        count_d        = count_q;
        compare_d      = compare_q;
        entryhi_d      = entryhi_q;
        status_d       = status_q;
        cause_d        = cause_q;
        epc_d          = epc_q;
        ebase_d        = ebase_q;
        count_toggle_d = ~count_toggle_q;
        hw_sync1_d     = bus.hw_int;
        hw_sync2_d     = hw_sync1_q;

        // Count runs at half the clock rate; a software load restarts the phase.
        if (wr_count) begin
            count_d        = bus.wdata;
            count_toggle_d = 1'b0;
        end else begin
            count_d = count_q + {31'd0, count_toggle_q};
        end

        if (count_q == compare_q) begin
            cause_d[30] = 1'b1;
        end
        if (wr_cmp) begin
            compare_d   = bus.wdata;
            cause_d[30] = 1'b0;
        end

        // IP7 folds in the registered TI, so a timer match reaches it one cycle after TI.
        cause_d[15:10] = {hw_sync2_q[5] | cause_q[30], hw_sync2_q[4:0]};

        if (wr_status) begin
            status_d = (status_q & ~STATUS_WMASK) | (bus.wdata & STATUS_WMASK);
        end
        if (wr_cause) begin
            cause_d = (cause_d & ~CAUSE_WMASK) | (bus.wdata & CAUSE_WMASK);
        end
        if (wr_enthi) begin
            entryhi_d = (entryhi_q & ~ENTHI_WMASK) | (bus.wdata & ENTHI_WMASK);
        end
        if (wr_epc) begin
            epc_d = bus.wdata;
        end
        if (wr_ebase) begin
            ebase_d = {2'b10, bus.wdata[29:12], ebase_q[11:0]};
        end

        // Exception-side updates come last so they override any same-cycle MTC0 to the same field.
        if (bus.cp0_exp_en) begin
            if (!status_q[1]) begin
                epc_d       = bus.cp0_exp_epc;
                cause_d[31] = bus.cp0_exp_bd;
            end
            status_d[1]   = 1'b1;
            cause_d[6:2]  = bus.cp0_exp_code;
            if (bus.cp0_exp_bad_vaddr_wen) begin
                badvaddr_d = bus.cp0_exp_bad_vaddr;
            end
            if (bus.cp0_exp_asid_en) begin
                entryhi_d[31:13] = bus.cp0_exp_bad_vaddr[31:13];
                entryhi_d[7:0]   = bus.cp0_exp_asid;
            end
        end else if (bus.cp0_exl_clean) begin
            status_d[1] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            badvaddr_q     <= 32'd0;
            count_q        <= 32'd0;
            compare_q      <= 32'd0;
            entryhi_q      <= 32'd0;
            status_q       <= STATUS_RST;
            cause_q        <= 32'd0;
            epc_q          <= 32'd0;
            ebase_q        <= EBASE_RST;
            count_toggle_q <= 1'b0;
            hw_sync1_q     <= 6'd0;
            hw_sync2_q     <= 6'd0;
        end else begin
            badvaddr_q     <= badvaddr_d;
            count_q        <= count_d;
            compare_q      <= compare_d;
            entryhi_q      <= entryhi_d;
            status_q       <= status_d;
            cause_q        <= cause_d;
            epc_q          <= epc_d;
            ebase_q        <= ebase_d;
            count_toggle_q <= count_toggle_d;
            hw_sync1_q     <= hw_sync1_d;
            hw_sync2_q     <= hw_sync2_d;
        end
    end

    always_comb begin
        bus.rdata = 32'd0;
        case ({bus.raddr, bus.rsel})
            A_BADV:   bus.rdata = badvaddr_q;
            A_COUNT:  bus.rdata = count_q;
            A_ENTHI:  bus.rdata = entryhi_q;
            A_CMP:    bus.rdata = compare_q;
            A_STATUS: bus.rdata = status_q;
            A_CAUSE:  bus.rdata = cause_q;
            A_EPC:    bus.rdata = epc_q;
            A_PRID:   bus.rdata = PRID;
            A_EBASE:  bus.rdata = ebase_q;
            A_CONFIG: bus.rdata = CONFIG0;
            default:  bus.rdata = 32'd0;
        endcase
    end

    assign bus.epc_address          = epc_q;
    assign bus.allow_interrupt      = status_q[0] & ~status_q[1];
    assign bus.interrupt_flag       = cause_q[15:8] & status_q[15:8];
    assign bus.cp0_ebase            = ebase_q;
    assign bus.cp0_use_special_iv   = cause_q[23];
    assign bus.cp0_use_bootstrap_iv = status_q[22];
    assign bus.exl_set              = status_q[1];
    assign bus.asid                 = entryhi_q[7:0];
endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: register-access vector table, hand-written timer/interrupt/exception
// sequences, then random traffic against a field-level reference model.
module tb_cp0_regfile;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cp0_regfile_if bus();

    cp0_regfile #(.PRID(32'h0000_4220), .CONFIG0(32'h8000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_compared = 0;
    int n_mismatch = 0;

    // Reference model: architectural fields held individually.
    logic [31:0] m_bad, m_cnt, m_cmp, m_ehi, m_epc;
    logic        m_tog, m_bev, m_exl, m_ie, m_iv, m_bd, m_ti;
    logic [7:0]  m_im;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_iphw, m_s1, m_s2;
    logic [4:0]  m_exc;
    logic [17:0] m_ebm;

    task automatic model_reset();
        m_bad = 0; m_cnt = 0; m_cmp = 0; m_ehi = 0; m_epc = 0;
        m_tog = 0; m_bev = 1; m_exl = 0; m_ie = 0; m_iv = 0; m_bd = 0; m_ti = 0;
        m_im = 0; m_ipsw = 0; m_iphw = 0; m_s1 = 0; m_s2 = 0; m_exc = 0; m_ebm = 0;
    endtask

    function automatic logic [31:0] m_status();
        return {9'd0, m_bev, 6'd0, m_im, 6'd0, m_exl, m_ie};
    endfunction

    function automatic logic [31:0] m_cause();
        return {m_bd, m_ti, 6'd0, m_iv, 7'd0, m_iphw, m_ipsw, 1'b0, m_exc, 2'b00};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input logic [2:0] s);
        if (s == 0 && a == 8)  return m_bad;
        if (s == 0 && a == 9)  return m_cnt;
        if (s == 0 && a == 10) return m_ehi;
        if (s == 0 && a == 11) return m_cmp;
        if (s == 0 && a == 12) return m_status();
        if (s == 0 && a == 13) return m_cause();
        if (s == 0 && a == 14) return m_epc;
        if (s == 0 && a == 15) return 32'h0000_4220;
        if (s == 1 && a == 15) return {2'b10, m_ebm, 12'd0};
        if (s == 0 && a == 16) return 32'h8000_0000;
        return 32'd0;
    endfunction

    function automatic logic is_w(input int n, input int s);
        return bus.wen && (int'(bus.waddr) == n) && (int'(bus.wsel) == s);
    endfunction

    task automatic model_step();
        logic        match, old_ti, old_exl;
        logic [31:0] wd;
        match   = (m_cnt == m_cmp);
        old_ti  = m_ti;
        old_exl = m_exl;
        wd      = bus.wdata;
        m_iphw  = {m_s2[5] | old_ti, m_s2[4:0]};
        m_s2    = m_s1;
        m_s1    = bus.hw_int;
        if (is_w(11, 0))  m_ti = 1'b0;
        else if (match)   m_ti = 1'b1;
        if (is_w(9, 0)) begin
            m_cnt = wd;
            m_tog = 1'b0;
        end else begin
            m_cnt = m_cnt + (m_tog ? 32'd1 : 32'd0);
            m_tog = ~m_tog;
        end
        if (is_w(11, 0)) m_cmp = wd;
        if (is_w(12, 0)) begin
            m_bev = wd[22]; m_im = wd[15:8]; m_exl = wd[1]; m_ie = wd[0];
        end
        if (is_w(13, 0)) begin
            m_iv = wd[23]; m_ipsw = wd[9:8];
        end
        if (is_w(10, 0)) m_ehi = {wd[31:13], m_ehi[12:8], wd[7:0]};
        if (is_w(14, 0)) m_epc = wd;
        if (is_w(15, 1)) m_ebm = wd[29:12];
        if (bus.cp0_exp_en) begin
            if (!old_exl) begin
                m_epc = bus.cp0_exp_epc;
                m_bd  = bus.cp0_exp_bd;
            end
            m_exl = 1'b1;
            m_exc = bus.cp0_exp_code;
            if (bus.cp0_exp_bad_vaddr_wen) m_bad = bus.cp0_exp_bad_vaddr;
            if (bus.cp0_exp_asid_en) m_ehi = {bus.cp0_exp_bad_vaddr[31:13], m_ehi[12:8], bus.cp0_exp_asid};
        end else if (bus.cp0_exl_clean) begin
            m_exl = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("rdata",       bus.rdata, m_read(bus.raddr, bus.rsel));
        chk("epc_address", bus.epc_address, m_epc);
        chk("allow_int",   {31'd0, bus.allow_interrupt}, {31'd0, m_ie & ~m_exl});
        chk("int_flag",    {24'd0, bus.interrupt_flag}, {24'd0, {m_iphw, m_ipsw} & m_im});
        chk("ebase",       bus.cp0_ebase, {2'b10, m_ebm, 12'd0});
        chk("special_iv",  {31'd0, bus.cp0_use_special_iv}, {31'd0, m_iv});
        chk("bootstrap",   {31'd0, bus.cp0_use_bootstrap_iv}, {31'd0, m_bev});
        chk("exl_set",     {31'd0, bus.exl_set}, {31'd0, m_exl});
        chk("asid",        {24'd0, bus.asid}, {24'd0, m_ehi[7:0]});
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.raddr = 0; bus.rsel = 0; bus.wen = 0; bus.waddr = 0; bus.wsel = 0; bus.wdata = 0;
        bus.hw_int = 0; bus.cp0_exp_en = 0; bus.cp0_exl_clean = 0; bus.cp0_exp_epc = 0;
        bus.cp0_exp_code = 0; bus.cp0_exp_bd = 0; bus.cp0_exp_bad_vaddr = 0;
        bus.cp0_exp_bad_vaddr_wen = 0; bus.cp0_exp_asid = 0; bus.cp0_exp_asid_en = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
        bus.wen = 1; bus.waddr = a; bus.wsel = s; bus.wdata = d;
        step();
        bus.wen = 0;
    endtask

    task automatic read_chk(input string name, input logic [4:0] a, input logic [2:0] s,
                            input logic [31:0] mask, input logic [31:0] exp);
        bus.raddr = a; bus.rsel = s;
        #1;
        chk(name, bus.rdata & mask, exp);
    endtask

    typedef struct {
        logic [4:0]  wa;
        logic [2:0]  ws;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic found;
        logic [4:0] addrs[12];
        logic [2:0] sels[12];

        tbl[0]  = '{5'd12, 3'd0, 32'hFFFF_FFFF, 32'h0040_FF03};
        tbl[1]  = '{5'd13, 3'd0, 32'hFFFF_FFFF, 32'h4080_8300};
        tbl[2]  = '{5'd15, 3'd1, 32'h0000_0000, 32'h8000_0000};
        tbl[3]  = '{5'd15, 3'd1, 32'hFFFF_FFFF, 32'hBFFF_F000};
        tbl[4]  = '{5'd10, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_E0FF};
        tbl[5]  = '{5'd14, 3'd0, 32'h1234_5678, 32'h1234_5678};
        tbl[6]  = '{5'd11, 3'd0, 32'h0000_0064, 32'h0000_0064};
        tbl[7]  = '{5'd8,  3'd0, 32'hDEAD_BEEF, 32'h0000_0000};
        tbl[8]  = '{5'd15, 3'd0, 32'h0000_0000, 32'h0000_4220};
        tbl[9]  = '{5'd16, 3'd0, 32'h0000_0000, 32'h8000_0000};
        tbl[10] = '{5'd7,  3'd0, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[11] = '{5'd12, 3'd1, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[12] = '{5'd12, 3'd0, 32'h0000_0000, 32'h0000_0000};

        idle_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Reset state
        read_chk("rst_status", 5'd12, 3'd0, 32'hFFFF_FFFF, 32'h0040_0000);
        read_chk("rst_ebase",  5'd15, 3'd1, 32'hFFFF_FFFF, 32'h8000_0000);
        chk("rst_bev", {31'd0, bus.cp0_use_bootstrap_iv}, 32'd1);
        chk("rst_allow", {31'd0, bus.allow_interrupt}, 32'd0);
        step();

        // Register access vectors
        for (int i = 0; i < 13; i++) begin
            bus.raddr = tbl[i].wa; bus.rsel = tbl[i].ws;
            mtc0(tbl[i].wa, tbl[i].ws, tbl[i].wd);
            read_chk($sformatf("vec%0d", i), tbl[i].wa, tbl[i].ws, 32'hFFFF_FFFF, tbl[i].exp);
        end

        // Exception commit, nested exception, ERET
        bus.cp0_exp_en = 1; bus.cp0_exp_epc = 32'h8000_1004; bus.cp0_exp_bd = 1;
        bus.cp0_exp_code = 5'h0c; bus.cp0_exp_bad_vaddr = 32'h0000_1234; bus.cp0_exp_bad_vaddr_wen = 1;
        step();
        idle_inputs();
        chk("exc1_epc", bus.epc_address, 32'h8000_1004);
        chk("exc1_exl", {31'd0, bus.exl_set}, 32'd1);
        read_chk("exc1_cause", 5'd13, 3'd0, 32'h8000_007C, 32'h8000_0030);
        read_chk("exc1_badv",  5'd8,  3'd0, 32'hFFFF_FFFF, 32'h0000_1234);
        bus.cp0_exp_en = 1; bus.cp0_exp_epc = 32'h8000_2000; bus.cp0_exp_bd = 0; bus.cp0_exp_code = 5'h04;
        step();
        idle_inputs();
        chk("exc2_epc", bus.epc_address, 32'h8000_1004);
        read_chk("exc2_cause", 5'd13, 3'd0, 32'h8000_007C, 32'h8000_0010);
        bus.cp0_exl_clean = 1;
        step();
        bus.cp0_exl_clean = 0;
        chk("eret_exl", {31'd0, bus.exl_set}, 32'd0);

        // Count/Compare timer
        mtc0(5'd12, 3'd0, 32'h0000_8001);
        mtc0(5'd11, 3'd0, 32'd5);
        mtc0(5'd9,  3'd0, 32'd0);
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (bus.interrupt_flag == 8'h80) found = 1;
        end
        chk("timer_irq", {24'd0, bus.interrupt_flag}, 32'h80);
        mtc0(5'd11, 3'd0, 32'd1000);
        read_chk("ti_clear", 5'd13, 3'd0, 32'h4000_0000, 32'h0);
        chk("ip7_lag", {24'd0, bus.interrupt_flag}, 32'h80);
        step();
        chk("ip7_clear", {24'd0, bus.interrupt_flag}, 32'h00);

        // External interrupt through the synchronizer
        mtc0(5'd12, 3'd0, 32'h0000_0400);
        bus.hw_int = 6'b000001;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("hw_set_%0d", k), {24'd0, bus.interrupt_flag}, (k == 3) ? 32'h04 : 32'h00);
        end
        bus.hw_int = 6'b000000;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("hw_clr_%0d", k), {24'd0, bus.interrupt_flag}, (k == 3) ? 32'h00 : 32'h04);
        end

        // Exception and MTC0 Status in the same cycle
        bus.cp0_exp_en = 1; bus.cp0_exp_epc = 32'h8000_3000; bus.cp0_exp_code = 5'h08;
        bus.cp0_exp_asid = 8'h5A; bus.cp0_exp_asid_en = 1; bus.cp0_exp_bad_vaddr = 32'hABCD_E000;
        mtc0(5'd12, 3'd0, 32'h0000_0001);
        idle_inputs();
        chk("same_exl", {31'd0, bus.exl_set}, 32'd1);
        read_chk("same_ie", 5'd12, 3'd0, 32'h0000_0003, 32'h0000_0003);
        chk("same_allow", {31'd0, bus.allow_interrupt}, 32'd0);
        chk("same_asid", {24'd0, bus.asid}, 32'h5A);
        bus.cp0_exl_clean = 1;
        step();
        bus.cp0_exl_clean = 0;

        // Random traffic against the model
        addrs = '{5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd15, 5'd16, 5'd3, 5'd12};
        sels  = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd2};
        for (int c = 0; c < 600; c++) begin
            int wi, ri, ev;
            wi = $urandom_range(0, 11);
            ri = $urandom_range(0, 11);
            ev = $urandom_range(0, 7);
            bus.raddr = addrs[ri]; bus.rsel = sels[ri];
            bus.wen   = ($urandom_range(0, 2) == 0);
            bus.waddr = addrs[wi]; bus.wsel = sels[wi];
            bus.wdata = (addrs[wi] == 5'd9 || addrs[wi] == 5'd11) ? 32'($urandom_range(0, 7)) : $urandom;
            if ($urandom_range(0, 7) == 0) bus.hw_int = 6'($urandom);
            bus.cp0_exp_en    = (ev == 0);
            bus.cp0_exl_clean = (ev == 1);
            bus.cp0_exp_epc   = $urandom;
            bus.cp0_exp_code  = 5'($urandom);
            bus.cp0_exp_bd    = 1'($urandom);
            bus.cp0_exp_bad_vaddr     = $urandom;
            bus.cp0_exp_bad_vaddr_wen = 1'($urandom);
            bus.cp0_exp_asid          = 8'($urandom);
            bus.cp0_exp_asid_en       = 1'($urandom);
            step();
        end
        idle_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end
endmodule
